axi_mem_stub: RTL and testbench

Parametrised AXI4 slave model backed by a word-addressed memory, used as a bench/integration endpoint. It supports FIXED, INCR and WRAP bursts, narrow transfers, byte strobes and per-beat SLVERR for illegal or out-of-range accesses. It has independent read and write engines, each handling one outstanding transaction. It sits behind an interconnect or bridge under test as the terminal slave.

---
 rtl/amba_pkg.sv | 31 +++
 rtl/axi_burst_addr.sv | 41 ++++
 rtl/axi_mem_stub.sv | 240 ++++++++++++++++++++++++
 tb/tb_axi_mem_stub.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/amba_pkg.sv
// AXI encodings and engine state types shared by the memory stub and its
// burst address helper.
package amba_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

  // awlen/arlen encodings of the only legal WRAP burst lengths (2/4/8/16 beats)
  localparam logic [7:0] WRAP_LEN2  = 8'd1;
  localparam logic [7:0] WRAP_LEN4  = 8'd3;
  localparam logic [7:0] WRAP_LEN8  = 8'd7;
  localparam logic [7:0] WRAP_LEN16 = 8'd15;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return len inside {WRAP_LEN2, WRAP_LEN4, WRAP_LEN8, WRAP_LEN16};
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Per-beat address step and legality check for one AXI burst beat.
module axi_burst_addr #(
  parameter int AWIDTH = 10,
  parameter int DSIZE  = 2,
  parameter int DEPTH  = 256
) (
  input  logic [AWIDTH-1:0] addr,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [AWIDTH-1:0] next_addr,
  output logic              illegal
);
  import amba_pkg::*;

  localparam int IXW = AWIDTH - DSIZE;

  logic [AWIDTH-1:0] w_step;
  logic [AWIDTH-1:0] w_span;
  logic [AWIDTH-1:0] w_mask;
  logic [AWIDTH-1:0] w_incr;
  logic [IXW-1:0]    w_idx;

  always_comb begin
    w_step = AWIDTH'(1) << size;
    w_span = (AWIDTH'(len) + AWIDTH'(1)) << size;
    w_mask = w_span - AWIDTH'(1);
    w_incr = addr + w_step;
    w_idx  = addr[AWIDTH-1:DSIZE];
    case (burst)
      FIXED:   next_addr = addr;
      // stay inside the span-aligned window, low bits roll over to its base
      WRAP:    next_addr = (addr & ~w_mask) | (w_incr & w_mask);
      default: next_addr = w_incr;
    endcase
    illegal = (32'(size) > DSIZE) || (burst == 2'b11) ||
              ((burst == WRAP) && !wrap_len_ok(len)) ||
              (32'(w_idx) >= DEPTH);
  end

endmodule

// File: rtl/axi_mem_stub.sv
// AXI4 slave backed by a word-addressed memory, with independent
// single-outstanding write (AW/W/B) and read (AR/R) engines.
module axi_mem_stub #(
  parameter  int IWIDTH = 4,
  parameter  int AWIDTH = 10,
  parameter  int DSIZE  = 2,
  parameter  int DEPTH  = 256,
  localparam int DBYTES = 1 << DSIZE,
  localparam int DWIDTH = DBYTES * 8
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [IWIDTH-1:0] awid,
  input  logic [AWIDTH-1:0] awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awlock,
  input  logic [3:0]        awcache,
  input  logic [2:0]        awprot,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [DBYTES-1:0] wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [IWIDTH-1:0] bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [IWIDTH-1:0] arid,
  input  logic [AWIDTH-1:0] araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arlock,
  input  logic [3:0]        arcache,
  input  logic [2:0]        arprot,
  input  logic              arvalid,
  output logic              arready,
  output logic [IWIDTH-1:0] rid,
  output logic [DWIDTH-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready
);
  import amba_pkg::*;

  localparam int MW = $clog2(DEPTH);

  logic [DWIDTH-1:0] r_mem [DEPTH];

  logic w_unused;
  assign w_unused = ^{awlock, awcache, awprot, arlock, arcache, arprot};

  // ---------------- write engine ----------------
  wr_state_t         r_wst, w_wst_nxt;
  logic [IWIDTH-1:0] r_bid;
  logic [1:0]        r_bresp;
  logic [AWIDTH-1:0] r_waddr;
  logic [7:0]        r_wlen, r_wcnt;
  logic [2:0]        r_wsize;
  logic [1:0]        r_wburst;
  logic              r_werr;
  logic [AWIDTH-1:0] w_wnext;
  logic              w_willegal, w_aw_hs, w_w_hs, w_b_hs, w_wfinal, w_wbad;
  logic [MW-1:0]     w_widx;

  assign w_aw_hs  = awvalid & awready;
  assign w_w_hs   = wvalid & wready;
  assign w_b_hs   = bvalid & bready;
  assign w_wfinal = (r_wcnt == r_wlen);
  assign w_wbad   = w_willegal | (wlast != w_wfinal);
  assign w_widx   = r_waddr[DSIZE +: MW];
  assign bid      = r_bid;
  assign bresp    = r_bresp;

  axi_burst_addr #(.AWIDTH(AWIDTH), .DSIZE(DSIZE), .DEPTH(DEPTH)) u_wr_addr (
    .addr(r_waddr), .size(r_wsize), .len(r_wlen), .burst(r_wburst),
    .next_addr(w_wnext), .illegal(w_willegal)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_wst <= W_IDLE;
    else        r_wst <= w_wst_nxt;
  end

  always_comb begin
    w_wst_nxt = r_wst;
    case (r_wst)
      W_IDLE:  if (w_aw_hs)             w_wst_nxt = W_DATA;
      W_DATA:  if (w_w_hs && w_wfinal)  w_wst_nxt = W_RESP;
      W_RESP:  if (w_b_hs)              w_wst_nxt = W_IDLE;
      default:                          w_wst_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    awready = (r_wst == W_IDLE);
    wready  = (r_wst == W_DATA);
    bvalid  = (r_wst == W_RESP);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_bid    <= '0;
      r_bresp  <= OKAY;
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wcnt   <= '0;
      r_wsize  <= '0;
      r_wburst <= '0;
      r_werr   <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_bid    <= awid;
        r_waddr  <= awaddr;
        r_wlen   <= awlen;
        r_wsize  <= awsize;
        r_wburst <= awburst;
        r_wcnt   <= '0;
        r_werr   <= 1'b0;
      end
      // the beat counter, not wlast, closes the burst
      if (w_w_hs) begin
        r_waddr <= w_wnext;
        r_wcnt  <= r_wcnt + 8'd1;
        r_werr  <= r_werr | w_wbad;
        if (w_wfinal) r_bresp <= (r_werr | w_wbad) ? SLVERR : OKAY;
      end
    end
  end

  // contents survive reset, so no reset branch
  always_ff @(posedge aclk) begin
    if (w_w_hs && !w_willegal) begin
      for (int b = 0; b < DBYTES; b++)
        if (wstrb[b]) r_mem[w_widx][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  // ---------------- read engine ----------------
  rd_state_t         r_rst, w_rst_nxt;
  logic [IWIDTH-1:0] r_rid;
  logic [DWIDTH-1:0] r_rdata;
  logic [1:0]        r_rresp;
  logic              r_rlast;
  logic [AWIDTH-1:0] r_raddr;
  logic [7:0]        r_rlen, r_rcnt;
  logic [2:0]        r_rsize;
  logic [1:0]        r_rburst;
  logic [AWIDTH-1:0] w_rsel_addr, w_rnext;
  logic [7:0]        w_rsel_len;
  logic [2:0]        w_rsel_size;
  logic [1:0]        w_rsel_burst;
  logic              w_rillegal, w_ar_hs, w_r_hs, w_rfetch;
  logic [MW-1:0]     w_ridx;

  assign w_ar_hs  = arvalid & arready;
  assign w_r_hs   = rvalid & rready;
  assign w_rfetch = w_ar_hs | (w_r_hs & ~r_rlast);
  assign w_ridx   = w_rsel_addr[DSIZE +: MW];
  assign rid      = r_rid;
  assign rdata    = r_rdata;
  assign rresp    = r_rresp;
  assign rlast    = r_rlast;

  // first beat is fetched straight from the AR fields, later beats from the latched burst
  always_comb begin
    if (r_rst == R_IDLE) begin
      w_rsel_addr  = araddr;
      w_rsel_len   = arlen;
      w_rsel_size  = arsize;
      w_rsel_burst = arburst;
    end else begin
      w_rsel_addr  = r_raddr;
      w_rsel_len   = r_rlen;
      w_rsel_size  = r_rsize;
      w_rsel_burst = r_rburst;
    end
  end

  axi_burst_addr #(.AWIDTH(AWIDTH), .DSIZE(DSIZE), .DEPTH(DEPTH)) u_rd_addr (
    .addr(w_rsel_addr), .size(w_rsel_size), .len(w_rsel_len), .burst(w_rsel_burst),
    .next_addr(w_rnext), .illegal(w_rillegal)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_rst <= R_IDLE;
    else        r_rst <= w_rst_nxt;
  end

  always_comb begin
    w_rst_nxt = r_rst;
    case (r_rst)
      R_IDLE:  if (w_ar_hs)           w_rst_nxt = R_DATA;
      R_DATA:  if (w_r_hs && r_rlast) w_rst_nxt = R_IDLE;
      default:                        w_rst_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    arready = (r_rst == R_IDLE);
    rvalid  = (r_rst == R_DATA);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_rid    <= '0;
      r_rdata  <= '0;
      r_rresp  <= OKAY;
      r_rlast  <= 1'b0;
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rcnt   <= '0;
      r_rsize  <= '0;
      r_rburst <= '0;
    end else begin
      if (w_ar_hs) begin
        r_rid    <= arid;
        r_rlen   <= arlen;
        r_rsize  <= arsize;
        r_rburst <= arburst;
        r_rcnt   <= '0;
        r_rlast  <= (arlen == 8'd0);
      end else if (w_r_hs) begin
        r_rcnt  <= r_rcnt + 8'd1;
        r_rlast <= ~r_rlast & ((r_rcnt + 8'd1) == r_rlen);
      end
      if (w_rfetch) begin
        r_raddr <= w_rnext;
        r_rdata <= w_rillegal ? '0 : r_mem[w_ridx];
        r_rresp <= w_rillegal ? SLVERR : OKAY;
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_stub.sv
// Randomised and directed bench for axi_mem_stub against a burst-level memory model.
module tb_axi_mem_stub;
  localparam int IW = 4, AW = 10, DS = 2;
  // depth below the address space so out-of-range beats are reachable
  localparam int DEP = 192;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic [IW-1:0] awid, arid, bid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize, awprot, arprot;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic [3:0]    awcache, arcache, wstrb;
  logic          awlock, arlock;
  logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic          arvalid, arready, rvalid, rready, rlast;
  logic [31:0]   wdata, rdata;

  always #5 aclk = ~aclk;

  axi_mem_stub #(.IWIDTH(IW), .AWIDTH(AW), .DSIZE(DS), .DEPTH(DEP)) dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  logic [31:0] mdl [DEP];
  logic [31:0] wd  [256];
  logic [3:0]  ws  [256];
  bit          wlf [256];
  int nchk = 0, nerr = 0;

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int beat_addr(input int a, input int sz, input int ln, input int bu, input int i);
    int step = 1 << sz;
    int span = (ln + 1) * step;
    int base = a - (a % span);
    if (bu == 0) return a;
    if (bu == 2) return base + ((a - base + i * step) % span);
    return (a + i * step) % (1 << AW);
  endfunction

  function automatic bit legal(input int a, input int sz, input int ln, input int bu);
    if (sz > DS || bu == 3) return 1'b0;
    if (bu == 2 && !(ln == 1 || ln == 3 || ln == 7 || ln == 15)) return 1'b0;
    return (a >> DS) < DEP;
  endfunction

  task automatic aw_send(input int id, input int a, input int ln, input int sz, input int bu);
    int n = 0;
    awid = IW'(id); awaddr = AW'(a); awlen = 8'(ln); awsize = 3'(sz); awburst = 2'(bu);
    awvalid = 1'b1;
    while (!awready && n < 50) begin tick(); n++; end
    chk("aw_accept", awready, 1);
    tick();
    awvalid = 1'b0;
    chk("wready_on", wready, 1);
    chk("awready_busy", awready, 0);
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s, input logic l);
    int n = 0;
    if ($urandom_range(0, 3) == 0) tick();
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    while (!wready && n < 50) begin tick(); n++; end
    chk("w_accept", wready, 1);
    tick();
    wvalid = 1'b0;
  endtask

  task automatic do_write(input int id, input int a, input int ln, input int sz, input int bu);
    bit err = 1'b0;
    for (int i = 0; i <= ln; i++) begin
      int ba = beat_addr(a, sz, ln, bu, i);
      if (legal(ba, sz, ln, bu)) begin
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) mdl[ba >> DS][b*8 +: 8] = wd[i][b*8 +: 8];
      end else err = 1'b1;
      if (wlf[i]) err = 1'b1;
    end
    aw_send(id, a, ln, sz, bu);
    for (int i = 0; i <= ln; i++) w_send(wd[i], ws[i], (i == ln) ^ wlf[i]);
    chk("bvalid_on", bvalid, 1);
    chk("wready_off", wready, 0);
    repeat ($urandom_range(0, 2)) begin tick(); chk("bvalid_hold", bvalid, 1); end
    chk("bid", bid, 64'(id));
    chk("bresp", bresp, err ? 64'd2 : 64'd0);
    bready = 1'b1; tick(); bready = 1'b0;
    chk("bvalid_off", bvalid, 0);
    chk("awready_back", awready, 1);
  endtask

  task automatic do_read(input int id, input int a, input int ln, input int sz, input int bu,
                         input bit stall);
    int n = 0;
    arid = IW'(id); araddr = AW'(a); arlen = 8'(ln); arsize = 3'(sz); arburst = 2'(bu);
    arvalid = 1'b1;
    while (!arready && n < 50) begin tick(); n++; end
    chk("ar_accept", arready, 1);
    tick();
    arvalid = 1'b0;
    chk("arready_busy", arready, 0);
    for (int i = 0; i <= ln; i++) begin
      int ba = beat_addr(a, sz, ln, bu, i);
      bit lg = legal(ba, sz, ln, bu);
      logic [31:0] ed = lg ? mdl[ba >> DS] : 32'h0;
      chk("rvalid", rvalid, 1);
      chk("rid", rid, 64'(id));
      chk("rdata", rdata, ed);
      chk("rresp", rresp, lg ? 64'd0 : 64'd2);
      chk("rlast", rlast, i == ln);
      if (stall || $urandom_range(0, 3) == 0) begin
        rready = 1'b0; tick();
        chk("rvalid_stall", rvalid, 1);
        chk("rdata_stall", rdata, ed);
        chk("rresp_stall", rresp, lg ? 64'd0 : 64'd2);
        chk("rlast_stall", rlast, i == ln);
      end
      rready = 1'b1; tick(); rready = 1'b0;
    end
    chk("rvalid_off", rvalid, 0);
    chk("arready_back", arready, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awlock = 1'b0;
    awcache = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arlock = 1'b0;
    arcache = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_awready", awready, 1);
    chk("rst_arready", arready, 1);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_bid", bid, 0);
    chk("rst_rid", rid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rdata", rdata, 0);
    areset = 1'b0;
    tick();

    // fill every word so the model is fully known
    for (int i = 0; i < DEP; i++) begin wd[i] = $urandom; ws[i] = 4'hF; wlf[i] = 1'b0; end
    do_write(1, 0, DEP - 1, 2, 1);
    do_read(2, 0, DEP - 1, 2, 1, 1'b0);

    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; wlf[i] = 1'b0; end
    do_write(3, 'h10, 3, 2, 1);
    do_read(4, 'h10, 3, 2, 1, 1'b0);

    for (int i = 0; i < 4; i++) wd[i] = 32'hB0 + 32'(i);
    do_write(5, 'h18, 3, 2, 2);
    do_read(6, 'h10, 3, 2, 1, 1'b0);
    do_read(7, 'h18, 3, 2, 2, 1'b0);
    for (int i = 0; i < 3; i++) wd[i] = 32'hC0 + 32'(i);
    do_write(8, 'h18, 2, 2, 2);
    do_read(9, 'h10, 3, 2, 1, 1'b0);

    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
    do_write(10, 0, 0, 2, 1);
    wd[0] = 32'h1122_3344; ws[0] = 4'b0101;
    do_write(11, 0, 0, 2, 1);
    do_read(12, 0, 0, 2, 1, 1'b0);

    do_read(13, 'h3FC, 1, 2, 1, 1'b1);
    wd[0] = $urandom; wd[1] = $urandom; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(14, (DEP - 1) * 4, 1, 2, 1);
    do_read(15, (DEP - 1) * 4, 1, 2, 1, 1'b0);

    // reset in the middle of beat 2 of an 8-beat write
    wd[0] = $urandom; wd[1] = $urandom;
    aw_send(5, 'h40, 7, 2, 1);
    w_send(wd[0], 4'hF, 1'b0);
    mdl['h40 >> DS] = wd[0];
    wdata = wd[1]; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    #2 areset = 1'b1;
    #1;
    chk("midrst_awready", awready, 1);
    chk("midrst_wready", wready, 0);
    chk("midrst_bvalid", bvalid, 0);
    wvalid = 1'b0;
    tick();
    areset = 1'b0;
    tick();
    do_read(6, 'h40, 1, 2, 1, 1'b0);
    wd[0] = $urandom; ws[0] = 4'hF; wlf[0] = 1'b0;
    do_write(7, 'h40, 0, 2, 1);
    do_read(8, 'h40, 0, 2, 1, 1'b0);

    for (int t = 0; t < 60; t++) begin
      int bu = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      int sz = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      int ln = (bu == 2) ? (($urandom_range(0, 5) == 0) ? 2 : (2 << $urandom_range(0, 3)) - 1)
                         : int'($urandom_range(0, 7));
      int a  = int'($urandom_range(0, 255)) * 4;
      int id = int'($urandom_range(0, 15));
      for (int i = 0; i <= ln; i++) begin
        wd[i]  = $urandom;
        ws[i]  = 4'($urandom_range(0, 15));
        wlf[i] = ($urandom_range(0, 19) == 0);
      end
      if ($urandom_range(0, 1) == 1) do_write(id, a, ln, sz, bu);
      else                           do_read(id, a, ln, sz, bu, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
